// File: rtl/iq_sample_packer_if.sv
// ---------------------------------------------------------------------------
// iq_sample_packer_if
//
// Bundles the sample-side and FIFO-side signals of the I/Q sample packer.
//
//   i_data / i_valid   I-channel sample and its one-cycle strobe
//   q_data / q_valid   Q-channel sample and its one-cycle strobe
//   fifo_full          sample FIFO full flag
//   fifo_data          packed 2*SAMPLE_WIDTH word written to the FIFO
//   fifo_we            FIFO write enable
//
// Modports:
//   master  the packer: consumes samples and fifo_full, drives the write port
//   slave   the surroundings: ADC interfaces and FIFO
// ---------------------------------------------------------------------------
interface iq_sample_packer_if #(
  parameter int SAMPLE_WIDTH = 32
);

  logic [SAMPLE_WIDTH-1:0]   i_data;
  logic                      i_valid;
  logic [SAMPLE_WIDTH-1:0]   q_data;
  logic                      q_valid;
  logic                      fifo_full;
  logic [2*SAMPLE_WIDTH-1:0] fifo_data;
  logic                      fifo_we;

  modport master (
    input  i_data,
    input  i_valid,
    input  q_data,
    input  q_valid,
    input  fifo_full,
    output fifo_data,
    output fifo_we
  );

  modport slave (
    output i_data,
    output i_valid,
    output q_data,
    output q_valid,
    output fifo_full,
    input  fifo_data,
    input  fifo_we
  );

endinterface

// File: rtl/iq_sample_packer.sv
// ---------------------------------------------------------------------------
// iq_sample_packer
//
// Pairs I- and Q-channel samples into {I, Q} words and writes them into the
// sample FIFO in frames of FRAME_PAIRS pairs. Each channel has a one-deep
// hold; a lone sample waits at most SKEW_MAX cycles for its partner before
// being discarded. Overruns (a strobe on an already full hold) overwrite the
// hold. Every discarded sample bumps drop_cnt and sets the sticky skew_err.
//
// Build option:
//   IQ_PACKER_HEADER_EN  when defined, each frame is preceded by a header
//                        word {16'hA5C3, seq_num, FRAME_PAIRS[15:0], 16'h0}.
//                        When undefined no header is written and the FSM
//                        goes straight from IDLE to DATA.
//
// Ports:
//   clk         system clock
//   arstn       asynchronous active-low reset
//   enable      run enable (level); low returns to IDLE and flushes holds
//   bus         iq_sample_packer_if.master: samples in, FIFO write port out
//   frame_done  one-cycle pulse coincident with the last data write of a frame
//   seq_num     completed-frame count, wraps
//   drop_cnt    discarded-sample count, saturates at 16'hFFFF
//   skew_err    sticky skew/overrun flag, cleared only by reset
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module iq_sample_packer #(
  parameter int SAMPLE_WIDTH = 32,
  parameter int FRAME_PAIRS  = 127,
  parameter int SKEW_MAX     = 15
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  enable,
  iq_sample_packer_if.master    bus,
  output logic                  frame_done,
  output logic [15:0]           seq_num,
  output logic [15:0]           drop_cnt,
  output logic                  skew_err
);

  localparam int          WORD_WIDTH = 2 * SAMPLE_WIDTH;
  localparam logic [15:0] LAST_PAIR  = 16'(FRAME_PAIRS - 1);
  localparam logic [7:0]  SKEW_LIMIT = 8'(SKEW_MAX);
  localparam int          I_CH       = 0;
  localparam int          Q_CH       = 1;

`ifdef IQ_PACKER_HEADER_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd2
  } state_t;
`endif

  state_t state_q, state_d;

  // Per-channel holding state, index 0 = I, index 1 = Q.
  logic [1:0]                   full_q, full_d;
  logic [1:0][7:0]              age_q, age_d;
  logic [1:0][SAMPLE_WIDTH-1:0] hold_q;
  logic [1:0]                   load;

  logic [15:0]                  pair_cnt_q, pair_cnt_d;

  logic [1:0][SAMPLE_WIDTH-1:0] data_in;
  logic [1:0][SAMPLE_WIDTH-1:0] cand;
  logic [1:0]                   valid_in;
  logic [1:0]                   stb;
  logic [1:0]                   lone;
  logic [1:0]                   expire;
  logic [1:0]                   have;
  logic [1:0]                   overrun;

  logic                         active;
  logic                         data_fire;
  logic                         drain;
  logic                         last_pair;
  logic                         hdr_fire;
  logic [WORD_WIDTH-1:0]        pair_word;
  logic [WORD_WIDTH-1:0]        word_d;
  logic [2:0]                   drops;
  logic [16:0]                  drop_sum;

  logic                         fifo_we_q;
  logic [WORD_WIDTH-1:0]        fifo_data_q;

  assign data_in  = {bus.q_data, bus.i_data};
  assign valid_in = {bus.q_valid, bus.i_valid};

  assign bus.fifo_we   = fifo_we_q;
  assign bus.fifo_data = fifo_data_q;

`ifdef IQ_PACKER_HEADER_EN
  // frame_done is still high in the first HDR cycle while seq_num has not yet
  // advanced, so the header must carry the post-increment value.
  logic [15:0]           seq_hdr;
  logic [WORD_WIDTH-1:0] hdr_word;

  assign seq_hdr  = seq_num + {15'd0, frame_done};
  assign hdr_word = WORD_WIDTH'({16'hA5C3, seq_hdr, 16'(FRAME_PAIRS), 16'h0000});
`endif

  // -------------------------------------------------------------------------
  // Pairing, skew and overrun decisions
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a value before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    active = enable && (state_q != IDLE);
    stb    = valid_in & {2{active}};

    // A hold is lone when it is full and the other channel's hold is empty;
    // only then does its skew timer run.
    lone   = full_q & ~{full_q[I_CH], full_q[Q_CH]};

    expire[I_CH] = active && lone[I_CH] && (age_q[I_CH] == SKEW_LIMIT);
    expire[Q_CH] = active && lone[Q_CH] && (age_q[Q_CH] == SKEW_LIMIT);

    // A channel contributes to a pair from this cycle's strobe or from a
    // surviving hold; a simultaneous I/Q strobe pairs without touching holds.
    have = stb | (full_q & ~expire);

    for (int c = 0; c < 2; c++) begin
      cand[c] = stb[c] ? data_in[c] : hold_q[c];
    end

    data_fire = active && (state_q == DATA) && !bus.fifo_full && (&have);

    // When both holds were already full and the pair leaves now, the holds
    // are vacated this cycle: new strobes refill them instead of overrunning.
    drain   = data_fire && (&full_q);
    overrun = stb & full_q & {2{!drain}};

    pair_word = drain ? {hold_q[I_CH], hold_q[Q_CH]}
                      : {cand[I_CH], cand[Q_CH]};

    last_pair = data_fire && (pair_cnt_q == LAST_PAIR);

    drops    = 3'(overrun[I_CH]) + 3'(overrun[Q_CH])
             + 3'(expire[I_CH])  + 3'(expire[Q_CH]);
    drop_sum = {1'b0, drop_cnt} + 17'(drops);
  end

  // -------------------------------------------------------------------------
  // Hold and timer next state
  // -------------------------------------------------------------------------
  always_comb begin
    full_d = full_q;
    age_d  = age_q;
    load   = '0;

    if (!active) begin
      full_d = '0;
      age_d  = '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (data_fire) begin
          full_d[c] = drain && stb[c];
          load[c]   = drain && stb[c];
          age_d[c]  = '0;
        end else if (stb[c]) begin
          full_d[c] = 1'b1;
          load[c]   = 1'b1;
          age_d[c]  = '0;
        end else if (expire[c]) begin
          full_d[c] = 1'b0;
          age_d[c]  = '0;
        end else if (lone[c]) begin
          age_d[c]  = age_q[c] + 8'd1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Frame FSM, pair counter and write data
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    hdr_fire = 1'b0;

    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
`ifdef IQ_PACKER_HEADER_EN
        IDLE: state_d = HDR;
        HDR: begin
          if (!bus.fifo_full) begin
            hdr_fire = 1'b1;
            state_d  = DATA;
          end
        end
        DATA: begin
          if (last_pair) state_d = HDR;
        end
`else
        IDLE: state_d = DATA;
        DATA: state_d = DATA;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    if (!active || last_pair) begin
      pair_cnt_d = '0;
    end else if (data_fire) begin
      pair_cnt_d = pair_cnt_q + 16'd1;
    end else begin
      pair_cnt_d = pair_cnt_q;
    end

    word_d = fifo_data_q;
`ifdef IQ_PACKER_HEADER_EN
    if (hdr_fire) word_d = hdr_word;
`endif
    if (data_fire) word_d = pair_word;
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sample storage has no reset; the full bits alone say whether a
  // hold is meaningful, so clearing the data would only cost reset routing.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (load[c]) hold_q[c] <= data_in[c];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= IDLE;
      full_q      <= '0;
      age_q       <= '0;
      pair_cnt_q  <= '0;
      fifo_we_q   <= 1'b0;
      fifo_data_q <= '0;
      frame_done  <= 1'b0;
      seq_num     <= '0;
      drop_cnt    <= '0;
      skew_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      age_q       <= age_d;
      pair_cnt_q  <= pair_cnt_d;
      fifo_we_q   <= data_fire || hdr_fire;
      fifo_data_q <= word_d;
      frame_done  <= last_pair;

      // seq_num trails frame_done by one cycle.
      if (frame_done) seq_num <= seq_num + 16'd1;

      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

      if (drops != 3'd0) skew_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iq_sample_packer.sv
// ---------------------------------------------------------------------------
// tb_iq_sample_packer
//
// Directed bench for iq_sample_packer with FRAME_PAIRS=4, SKEW_MAX=15.
// The stimulus process pushes expected FIFO words (with their expected
// frame_done) into a queue; an independent monitor pops and compares on
// every fifo_we. Header words are expected only when IQ_PACKER_HEADER_EN
// is defined for the build.
// ---------------------------------------------------------------------------
module tb_iq_sample_packer;

  localparam int FP = 4;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  logic        clk;
  logic        arstn;
  logic        enable;
  logic        frame_done;
  logic [15:0] seq_num;
  logic [15:0] drop_cnt;
  logic        skew_err;

  iq_sample_packer_if #(.SAMPLE_WIDTH(32)) bus ();

  iq_sample_packer #(
    .SAMPLE_WIDTH (32),
    .FRAME_PAIRS  (FP),
    .SKEW_MAX     (15)
  ) dut (
    .clk        (clk),
    .arstn      (arstn),
    .enable     (enable),
    .bus        (bus),
    .frame_done (frame_done),
    .seq_num    (seq_num),
    .drop_cnt   (drop_cnt),
    .skew_err   (skew_err)
  );

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_pass;
  int          n_total;
  int          frame_pos;
  logic [15:0] exp_seq;
  logic        full_at_edge;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) full_at_edge <= bus.fifo_full;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---- reference model ----------------------------------------------------
  task automatic push_hdr();
`ifdef IQ_PACKER_HEADER_EN
    sb.push_back('{data: {16'hA5C3, exp_seq, 16'(FP), 16'h0000}, last: 1'b0});
`endif
  endtask

  task automatic push_pair(input logic [31:0] i_s, input logic [31:0] q_s);
    logic is_last;
    is_last = (frame_pos == FP - 1);
    sb.push_back('{data: {i_s, q_s}, last: is_last});
    if (is_last) begin
      frame_pos = 0;
      exp_seq   = exp_seq + 16'd1;
      push_hdr();
    end else begin
      frame_pos++;
    end
  endtask

  task automatic enable_on();
    enable    = 1'b1;
    frame_pos = 0;
    push_hdr();
  endtask

  // ---- stimulus helpers ---------------------------------------------------
  task automatic cyc(input logic iv, input logic [31:0] id, input logic qv, input logic [31:0] qd);
    @(negedge clk);
    bus.i_valid = iv;
    bus.i_data  = id;
    bus.q_valid = qv;
    bus.q_data  = qd;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // ---- monitor ------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (bus.fifo_we) begin
        check("write_after_full", 64'(full_at_edge), 64'd0);
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got data %h, expected no write", bus.fifo_data);
        end else begin
          mon_e = sb.pop_front();
          check("fifo_data", bus.fifo_data, mon_e.data);
          check("frame_done", 64'(frame_done), 64'(mon_e.last));
        end
      end else if (frame_done) begin
        n_total++;
        $display("FAIL frame_done_without_write: got 1, expected 0");
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  // ---- directed sequence --------------------------------------------------
  initial begin
    n_pass        = 0;
    n_total       = 0;
    frame_pos     = 0;
    exp_seq       = 16'd0;
    arstn         = 1'b0;
    enable        = 1'b0;
    bus.i_valid   = 1'b0;
    bus.i_data    = 32'h0;
    bus.q_valid   = 1'b0;
    bus.q_data    = 32'h0;
    bus.fifo_full = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_fifo_we",    64'(bus.fifo_we),   64'd0);
    check("rst_fifo_data",  bus.fifo_data,      64'd0);
    check("rst_frame_done", 64'(frame_done),    64'd0);
    check("rst_seq_num",    64'(seq_num),       64'd0);
    check("rst_drop_cnt",   64'(drop_cnt),      64'd0);
    check("rst_skew_err",   64'(skew_err),      64'd0);
    arstn = 1'b1;
    idle(2);

    // Frame 1: four simultaneous pairs, back to back.
    enable_on();
    idle(3);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 32'h100 + 32'(k), 1'b1, 32'h200 + 32'(k));
      push_pair(32'h100 + 32'(k), 32'h200 + 32'(k));
    end
    idle(4);
    check("seq_after_frame1", 64'(seq_num), 64'd1);

    // Q arrives 15 cycles after I: still a valid pair.
    cyc(1'b1, 32'h11, 1'b0, 32'h0);
    idle(14);
    cyc(1'b0, 32'h0, 1'b1, 32'h22);
    push_pair(32'h11, 32'h22);
    idle(3);
    check("skew15_drop_cnt", 64'(drop_cnt), 64'd0);
    check("skew15_skew_err", 64'(skew_err), 64'd0);

    // Two I strobes before one Q: newest I is paired, one drop.
    cyc(1'b1, 32'hA, 1'b0, 32'h0);
    cyc(1'b1, 32'hB, 1'b0, 32'h0);
    idle(2);
    cyc(1'b0, 32'h0, 1'b1, 32'hC);
    push_pair(32'hB, 32'hC);
    idle(3);
    check("overrun_drop_cnt", 64'(drop_cnt), 64'd1);
    check("overrun_skew_err", 64'(skew_err), 64'd1);

    // Lone I never paired: discarded at the edge ending cycle N+16.
    cyc(1'b1, 32'h33, 1'b0, 32'h0);
    idle(16);
    check("skew_not_yet_expired", 64'(drop_cnt), 64'd1);
    idle(1);
    check("skew_expired", 64'(drop_cnt), 64'd2);
    idle(2);

    // Backpressure for 20 cycles with a ready pair; I overruns meanwhile.
    cyc(1'b1, 32'h44, 1'b1, 32'h55);
    bus.fifo_full = 1'b1;
    push_pair(32'h66, 32'h55);
    idle(5);
    cyc(1'b1, 32'h66, 1'b0, 32'h0);
    idle(13);
    cyc(1'b0, 32'h0, 1'b0, 32'h0);
    bus.fifo_full = 1'b0;
    idle(1);
    check("bp_release_write", 64'(bus.fifo_we), 64'd1);
    idle(2);
    check("bp_drop_cnt", 64'(drop_cnt), 64'd3);

    // Close frame 2.
    cyc(1'b1, 32'h99, 1'b1, 32'h9A);
    push_pair(32'h99, 32'h9A);
    idle(4);
    check("seq_after_frame2", 64'(seq_num), 64'd2);

    // Partial frame 3 abandoned by dropping enable.
    cyc(1'b1, 32'hC0, 1'b1, 32'hD0);
    push_pair(32'hC0, 32'hD0);
    cyc(1'b1, 32'hC1, 1'b1, 32'hD1);
    push_pair(32'hC1, 32'hD1);
    idle(3);
    enable    = 1'b0;
    frame_pos = 0;
    idle(2);
    cyc(1'b1, 32'h77, 1'b1, 32'h88);
    idle(2);
    check("seq_after_abort", 64'(seq_num), 64'd2);

    // Restart: pair count starts over, full frame completes.
    enable_on();
    idle(3);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 32'h300 + 32'(k), 1'b1, 32'h400 + 32'(k));
      push_pair(32'h300 + 32'(k), 32'h400 + 32'(k));
    end
    idle(5);
    check("seq_after_restart", 64'(seq_num), 64'd3);
    check("final_drop_cnt",    64'(drop_cnt), 64'd3);
    check("final_skew_err",    64'(skew_err), 64'd1);
    check("scoreboard_empty",  64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
